// File: rtl/mc_pkg.sv
// mc_pkg: shared state codes, opcode/funct constants, ALUOp codes and
// instruction classes for the multi-cycle control unit.
// Optional feature macro: MC_ILLEGAL_HALT_EN (adds the S_HALT state).
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
`ifdef MC_ILLEGAL_HALT_EN
      S_WB     = 3'd4,
      S_HALT   = 3'd5
`else
      S_WB     = 3'd4
`endif
   } state_e;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;

   // ALU function codes
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_OR   = 3'd2;
   localparam logic [2:0] ALU_LUI  = 3'd3;
   localparam logic [2:0] ALU_SLL  = 3'd4;

   // Instruction classes as seen by the sequencer
   typedef enum logic [3:0] {
      IC_ILLEGAL,
      IC_ALU,      // addu, subu, sll, ori, lui: EXE -> WB
      IC_LOAD,     // lw, lb: EXE -> MEM -> WB
      IC_STORE,    // sw: EXE -> MEM
      IC_BEQ,
      IC_J,
      IC_JAL,
      IC_JR,
      IC_JALR
   } instr_class_e;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational decode of the held instruction word into
// an instruction class plus the datapath steering signals.
module mc_decode
   import mc_pkg::*;
(
   input  logic [31:0]  instr,
   output instr_class_e iclass,
   output logic         reg_dst,
   output logic         alu_src,
   output logic         mem_to_reg,
   output logic         ext_op,
   output logic [2:0]   alu_op,
   output logic         jump,
   output logic         reg_ra,
   output logic         j_reg,
   output logic         jalr,
   output logic         lb,
   output logic         npc_sel
);

   logic [5:0] op;
   logic [5:0] funct;
   logic       unused_instr_bits;

   assign op                = instr[31:26];
   assign funct             = instr[5:0];
   assign unused_instr_bits = ^instr[25:6];

   // Opcode/funct lookup; unknown encodings stay IC_ILLEGAL with all steering low
   always_comb begin
      iclass     = IC_ILLEGAL;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      ext_op     = 1'b0;
      alu_op     = ALU_ADD;
      jump       = 1'b0;
      reg_ra     = 1'b0;
      j_reg      = 1'b0;
      jalr       = 1'b0;
      lb         = 1'b0;
      npc_sel    = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            unique case (funct)
               FN_ADDU: begin iclass = IC_ALU; reg_dst = 1'b1; alu_op = ALU_ADD; end
               FN_SUBU: begin iclass = IC_ALU; reg_dst = 1'b1; alu_op = ALU_SUB; end
               FN_SLL:  begin iclass = IC_ALU; reg_dst = 1'b1; alu_op = ALU_SLL; end
               FN_JR:   begin iclass = IC_JR;  j_reg = 1'b1; end
               FN_JALR: begin iclass = IC_JALR; j_reg = 1'b1; jalr = 1'b1; reg_dst = 1'b1; end
               default: iclass = IC_ILLEGAL;
            endcase
         end
         OP_ORI: begin iclass = IC_ALU; alu_src = 1'b1; alu_op = ALU_OR; end
         OP_LUI: begin iclass = IC_ALU; alu_src = 1'b1; alu_op = ALU_LUI; end
         OP_LW: begin
            iclass = IC_LOAD; alu_src = 1'b1; mem_to_reg = 1'b1; ext_op = 1'b1;
         end
         OP_LB: begin
            iclass = IC_LOAD; alu_src = 1'b1; mem_to_reg = 1'b1; ext_op = 1'b1; lb = 1'b1;
         end
         OP_SW:  begin iclass = IC_STORE; alu_src = 1'b1; ext_op = 1'b1; end
         OP_BEQ: begin iclass = IC_BEQ; alu_op = ALU_SUB; ext_op = 1'b1; npc_sel = 1'b1; end
         OP_J:   begin iclass = IC_J; jump = 1'b1; end
         OP_JAL: begin iclass = IC_JAL; jump = 1'b1; reg_ra = 1'b1; end
         default: iclass = IC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencer (FETCH/DECODE/EXE/MEM/WB) driving the
// datapath write enables, plus retire pulse and wrapping retire counter.
// Optional feature macro: MC_ILLEGAL_HALT_EN (illegal instruction -> S_HALT).
module mc_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      Instr,
   input  logic             ComResult,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             ALUSrc,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             nPC_sel,
   output logic             ExtOp,
   output logic [2:0]       ALUOp,
   output logic             Jump,
   output logic             RegRa,
   output logic             JReg,
   output logic             Jalr,
   output logic             Lb,
   output logic [2:0]       state,
   output logic             retire,
   output logic [CNT_W-1:0] retire_cnt
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   instr_class_e     iclass;
   logic             pc_wr, ir_wr, reg_wr, mem_wr, ret;

   mc_decode u_decode (
      .instr      (Instr),
      .iclass     (iclass),
      .reg_dst    (RegDst),
      .alu_src    (ALUSrc),
      .mem_to_reg (MemtoReg),
      .ext_op     (ExtOp),
      .alu_op     (ALUOp),
      .jump       (Jump),
      .reg_ra     (RegRa),
      .j_reg      (JReg),
      .jalr       (Jalr),
      .lb         (Lb),
      .npc_sel    (nPC_sel)
   );

   // Next-state and single-cycle write-enable generation from state and class
   always_comb begin
      state_d = state_q;
      pc_wr   = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      mem_wr  = 1'b0;
      ret     = 1'b0;
      case (state_q)
         S_FETCH: begin
            pc_wr   = 1'b1;
            ir_wr   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
`ifdef MC_ILLEGAL_HALT_EN
            state_d = (iclass == IC_ILLEGAL) ? S_HALT : S_EXE;
`else
            state_d = S_EXE;
`endif
         end
         S_EXE: begin
            case (iclass)
               IC_ALU:             state_d = S_WB;
               IC_LOAD, IC_STORE:  state_d = S_MEM;
               IC_BEQ: begin
                  pc_wr   = ComResult;
                  ret     = 1'b1;
                  state_d = S_FETCH;
               end
               IC_J, IC_JR: begin
                  pc_wr   = 1'b1;
                  ret     = 1'b1;
                  state_d = S_FETCH;
               end
               IC_JAL, IC_JALR: begin
                  pc_wr   = 1'b1;
                  reg_wr  = 1'b1;
                  ret     = 1'b1;
                  state_d = S_FETCH;
               end
               default: begin
                  // illegal encodings retire as a nop
                  ret     = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            if (iclass == IC_STORE) begin
               mem_wr  = 1'b1;
               ret     = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_wr  = 1'b1;
            ret     = 1'b1;
            state_d = S_FETCH;
         end
`ifdef MC_ILLEGAL_HALT_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Enables are masked by the async reset so nothing writes while it is low
   always_comb begin
      PCWrite  = pc_wr  & reset;
      IRWrite  = ir_wr  & reset;
      RegWrite = reg_wr & reset;
      MemWrite = mem_wr & reset;
      retire   = ret    & reset;
      retire_cnt_d = retire_cnt_q + CNT_W'(retire);
   end

   // State register and retire counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_FETCH;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign state      = state_q;
   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized self-checking bench for mc_ctrl against a per-
// instruction reference model (cycle count, write events, steering table).
// Honours MC_ILLEGAL_HALT_EN for the illegal-instruction scenario.
module tb_mc_ctrl;

   localparam int CNT_W = 4;

   localparam int K_ADDU = 0,  K_SUBU = 1, K_SLL = 2,  K_JR  = 3,  K_JALR = 4;
   localparam int K_ORI  = 5,  K_LUI  = 6, K_LW  = 7,  K_LB  = 8,  K_SW   = 9;
   localparam int K_BEQ  = 10, K_J    = 11, K_JAL = 12, K_ILL = 13, K_ILLF = 14;

   logic             clk;
   logic             reset;
   logic [31:0]      Instr;
   logic             ComResult;
   logic             PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite;
   logic             nPC_sel, ExtOp, Jump, RegRa, JReg, Jalr, Lb, retire;
   logic [2:0]       ALUOp;
   logic [2:0]       state;
   logic [CNT_W-1:0] retire_cnt;

   int tests = 0;
   int fails = 0;
   int unsigned model_cnt = 0;

   mc_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ComResult  (ComResult),
      .PCWrite    (PCWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .ALUSrc     (ALUSrc),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .nPC_sel    (nPC_sel),
      .ExtOp      (ExtOp),
      .ALUOp      (ALUOp),
      .Jump       (Jump),
      .RegRa      (RegRa),
      .JReg       (JReg),
      .Jalr       (Jalr),
      .Lb         (Lb),
      .state      (state),
      .retire     (retire),
      .retire_cnt (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [31:0] make_instr(input int k);
      logic [31:0] r;
      logic [31:0] w;
      r = $urandom;
      case (k)
         K_ADDU:  w = {6'h00, r[25:6], 6'h21};
         K_SUBU:  w = {6'h00, r[25:6], 6'h23};
         K_SLL:   w = {6'h00, r[25:6], 6'h00};
         K_JR:    w = {6'h00, r[25:6], 6'h08};
         K_JALR:  w = {6'h00, r[25:6], 6'h09};
         K_ORI:   w = {6'h0D, r[25:0]};
         K_LUI:   w = {6'h0F, r[25:0]};
         K_LW:    w = {6'h23, r[25:0]};
         K_LB:    w = {6'h20, r[25:0]};
         K_SW:    w = {6'h2B, r[25:0]};
         K_BEQ:   w = {6'h04, r[25:0]};
         K_J:     w = {6'h02, r[25:0]};
         K_JAL:   w = {6'h03, r[25:0]};
         K_ILL:   w = {6'h3F, r[25:0]};
         default: w = {6'h00, r[25:6], 6'h3F};
      endcase
      return w;
   endfunction

   function automatic int cycles_of(input int k);
      if (k == K_LW || k == K_LB) return 5;
      if (k == K_BEQ || k == K_J || k == K_JAL || k == K_JR || k == K_JALR ||
          k == K_ILL || k == K_ILLF) return 3;
      return 4;
   endfunction

   function automatic logic writes_reg(input int k);
      return (k == K_ADDU || k == K_SUBU || k == K_SLL || k == K_ORI || k == K_LUI ||
              k == K_LW || k == K_LB || k == K_JAL || k == K_JALR);
   endfunction

   // {PCWrite, IRWrite, RegWrite, MemWrite, retire} expected in cycle c of n
   function automatic logic [4:0] exp_en(input int k, input int c, input int n, input logic cr);
      logic [4:0] e;
      e = 5'b00000;
      if (c == 0) e = 5'b11000;
      else if (c == n - 1) begin
         e[0] = 1'b1;
         e[2] = writes_reg(k);
         e[1] = (k == K_SW);
         e[4] = (k == K_J || k == K_JAL || k == K_JR || k == K_JALR) || (k == K_BEQ && cr);
      end
      return e;
   endfunction

   function automatic logic [2:0] exp_state(input int k, input int c);
      if (c < 3) return 3'(c);
      if (c == 3) return (k == K_SW || k == K_LW || k == K_LB) ? 3'd3 : 3'd4;
      return 3'd4;
   endfunction

   // steering {RegDst,ALUSrc,MemtoReg,ExtOp,ALUOp[2:0],Jump,RegRa,JReg,Jalr,Lb,nPC_sel}
   // returned as {mask, value}; RegDst/ExtOp/ALUOp only checked where defined
   function automatic logic [25:0] exp_steer(input int k);
      logic [12:0] v;
      logic [12:0] m;
      v = '0;
      m = 13'b0_1_1_0_111_111111;
      case (k)
         K_ADDU: begin v[12] = 1'b1; m[12] = 1'b1; v[8:6] = 3'd0; end
         K_SUBU: begin v[12] = 1'b1; m[12] = 1'b1; v[8:6] = 3'd1; end
         K_SLL:  begin v[12] = 1'b1; m[12] = 1'b1; v[8:6] = 3'd4; end
         K_JR:   begin v[3] = 1'b1; m[8:6] = 3'b000; end
         K_JALR: begin v[3] = 1'b1; v[2] = 1'b1; v[12] = 1'b1; m[12] = 1'b1; m[8:6] = 3'b000; end
         K_ORI:  begin v[11] = 1'b1; v[8:6] = 3'd2; m[12] = 1'b1; m[9] = 1'b1; end
         K_LUI:  begin v[11] = 1'b1; v[8:6] = 3'd3; m[12] = 1'b1; end
         K_LW:   begin v[11] = 1'b1; v[10] = 1'b1; v[9] = 1'b1; m[12] = 1'b1; m[9] = 1'b1; end
         K_LB:   begin v[11] = 1'b1; v[10] = 1'b1; v[9] = 1'b1; v[1] = 1'b1; m[12] = 1'b1; m[9] = 1'b1; end
         K_SW:   begin v[11] = 1'b1; v[9] = 1'b1; m[9] = 1'b1; end
         K_BEQ:  begin v[8:6] = 3'd1; v[0] = 1'b1; end
         K_J:    begin v[5] = 1'b1; m[8:6] = 3'b000; end
         K_JAL:  begin v[5] = 1'b1; v[4] = 1'b1; m[8:6] = 3'b000; end
         default: m = '0;
      endcase
      return {m, v};
   endfunction

   // ---------------- scenario tasks ----------------
   // Runs one instruction starting in FETCH (between edges), checking every cycle
   task automatic run_instr(input int k, input logic [31:0] w, input logic cr);
      int n;
      logic [4:0]  en;
      logic [12:0] st, sm, sv;
      n = cycles_of(k);
      Instr = w;
      ComResult = cr;
      #1;
      for (int c = 0; c < n; c++) begin
         tests++;
         if (state !== exp_state(k, c)) begin
            fails++;
            $display("FAIL state k=%0d cyc=%0d got=%0d exp=%0d", k, c, state, exp_state(k, c));
         end
         en = {PCWrite, IRWrite, RegWrite, MemWrite, retire};
         tests++;
         if (en !== exp_en(k, c, n, cr)) begin
            fails++;
            $display("FAIL enables k=%0d cyc=%0d got=%b exp=%b (pc,ir,rw,mw,ret)",
                     k, c, en, exp_en(k, c, n, cr));
         end
         if (c == 1) begin
            st = {RegDst, ALUSrc, MemtoReg, ExtOp, ALUOp, Jump, RegRa, JReg, Jalr, Lb, nPC_sel};
            {sm, sv} = exp_steer(k);
            tests++;
            if ((st & sm) !== (sv & sm)) begin
               fails++;
               $display("FAIL steer k=%0d instr=%h got=%b exp=%b mask=%b", k, w, st, sv, sm);
            end
         end
         @(posedge clk);
         #1;
      end
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      tests++;
      if (retire_cnt !== CNT_W'(model_cnt)) begin
         fails++;
         $display("FAIL retire_cnt k=%0d got=%0d exp=%0d", k, retire_cnt, model_cnt);
      end
   endtask

   // Pulse reset; leaves the bench mid-cycle in FETCH
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_cnt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      Instr = 32'h0;
      ComResult = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (state !== 3'd0 || retire_cnt !== '0) begin
         fails++;
         $display("FAIL reset_state got state=%0d cnt=%0d exp state=0 cnt=0", state, retire_cnt);
      end
      tests++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, retire} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_enables got=%b exp=00000",
                  {PCWrite, IRWrite, RegWrite, MemWrite, retire});
      end
      @(negedge clk);
      reset = 1'b1;
      model_cnt = 0;
   endtask

   task automatic test_reset_mid_sw();
      Instr = make_instr(K_SW);
      #1;
      repeat (2) begin @(posedge clk); #1; end
      tests++;
      if (state !== 3'd2) begin
         fails++;
         $display("FAIL sw_reach_exe got state=%0d exp=2", state);
      end
      reset = 1'b0;
      model_cnt = 0;
      #1;
      tests++;
      if (state !== 3'd0 || {PCWrite, IRWrite, RegWrite, MemWrite, retire} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_abort got state=%0d en=%b exp state=0 en=00000",
                  state, {PCWrite, IRWrite, RegWrite, MemWrite, retire});
      end
      repeat (2) begin
         @(posedge clk); #1;
         tests++;
         if (MemWrite !== 1'b0 || retire_cnt !== '0) begin
            fails++;
            $display("FAIL reset_hold got mw=%b cnt=%0d exp mw=0 cnt=0", MemWrite, retire_cnt);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (state !== 3'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_fetch got state=%0d pcw=%b irw=%b exp 0,1,1",
                  state, PCWrite, IRWrite);
      end
      run_instr(K_SW, make_instr(K_SW), 1'b0);
   endtask

   task automatic test_lw();
      run_instr(K_LW, 32'h8C220004, 1'b0);
   endtask

   task automatic test_beq();
      run_instr(K_BEQ, make_instr(K_BEQ), 1'b1);
      run_instr(K_BEQ, make_instr(K_BEQ), 1'b0);
   endtask

   task automatic test_jal();
      run_instr(K_JAL, 32'h0C000010, 1'b0);
   endtask

   task automatic test_illegal();
`ifdef MC_ILLEGAL_HALT_EN
      Instr = 32'hFC000000;
      #1;
      repeat (2) begin @(posedge clk); #1; end
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (state !== 3'd5 || {PCWrite, IRWrite, RegWrite, MemWrite, retire} !== 5'b00000 ||
             retire_cnt !== CNT_W'(model_cnt)) begin
            fails++;
            $display("FAIL halt cyc=%0d got state=%0d en=%b cnt=%0d exp state=5 en=00000 cnt=%0d",
                     c, state, {PCWrite, IRWrite, RegWrite, MemWrite, retire}, retire_cnt, model_cnt);
         end
         @(posedge clk); #1;
      end
      do_reset();
`else
      run_instr(K_ILL, 32'hFC000000, 1'b1);
      run_instr(K_ILLF, make_instr(K_ILLF), 1'b0);
`endif
   endtask

   task automatic test_random();
      int k;
      for (int i = 0; i < 200; i++) begin
`ifdef MC_ILLEGAL_HALT_EN
         k = int'($urandom_range(12));
`else
         k = int'($urandom_range(14));
`endif
         run_instr(k, make_instr(k), 1'($urandom));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 16; i++) run_instr(K_ADDU, make_instr(K_ADDU), 1'b0);
      tests++;
      if (retire_cnt !== '0) begin
         fails++;
         $display("FAIL cnt_wrap got=%0d exp=0", retire_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_sw();
      test_lw();
      test_beq();
      test_jal();
      test_illegal();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit that sits directly upstream of the datapath and drives all of its control inputs. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB, asserting architectural write enables only in the proper state. It decodes the held instruction word and samples the datapath's ComResult for branches. It also provides retire pulses and a retire counter for the bench.

Parameters:
CNT_W, 32, width of retire counter retire_cnt (wraps modulo 2^CNT_W)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
Instr  input  32  instruction register contents from datapath (stable after FETCH)
ComResult  input  1  ALU equality flag, sampled in EXE for beq
PCWrite  output  1  PC load enable
IRWrite  output  1  instruction register load enable
RegDst  output  1  write to rd (1) or rt (0)
ALUSrc  output  1  ALU B = extended immediate
MemtoReg  output  1  writeback from DM
RegWrite  output  1  GRF write enable
MemWrite  output  1  DM write enable
nPC_sel  output  1  branch-type next PC
ExtOp  output  1  sign extend (1) / zero extend (0)
ALUOp  output  3  ALU function code
Jump  output  1  j/jal target select
RegRa  output  1  force destination $31 and link data
JReg  output  1  PC from rs
Jalr  output  1  link data PC+4 to rd
Lb  output  1  byte load
state  output  3  current state code (debug)
retire  output  1  one-cycle pulse when an instruction completes
retire_cnt  output  CNT_W  retired instruction count

Behaviour:
- States: S_FETCH=0, S_DECODE=1, S_EXE=2, S_MEM=3, S_WB=4, S_HALT=5 (HALT only with macro).
- Reset (reset=0, async): state=S_FETCH, retire_cnt=0. All enables, including PCWrite and IRWrite, are forced to 0 while reset is low. Reset in any state aborts the instruction; no partial writes occur after reset asserts.
- FETCH: PCWrite=1 (PC+4) and IRWrite=1 for one cycle, then go to DECODE.
- DECODE: no write enables asserted; go to EXE. With the macro enabled, an illegal instruction goes to HALT instead.
- EXE:
  - R-type ALU, ori, lui: go to WB.
  - lw, lb, sw: go to MEM.
  - beq: PCWrite=ComResult, retire=1, go to FETCH.
  - j: PCWrite=1, retire=1, go to FETCH.
  - jal, jr, jalr: PCWrite=1. jal and jalr also assert RegWrite in this cycle (link = PC+4, already incremented). retire=1, go to FETCH.
- MEM:
  - sw: MemWrite=1, retire=1, go to FETCH.
  - lw, lb: go to WB.
- WB: RegWrite=1, retire=1, go to FETCH.
- Cycle counts: beq/j/jal/jr/jalr = 3; ALU ops and sw = 4; lw/lb = 5.
- Write enables are single-cycle pulses, decoded combinationally from state and Instr.
- Steering signals (RegDst, ALUSrc, MemtoReg, ExtOp, ALUOp, Jump, RegRa, JReg, Jalr, Lb, nPC_sel) are pure decode of Instr, independent of state.
- Decoded set by opcode/funct:
  - R-type (op 000000): addu f100001, subu f100011, sll f000000, jr f001000, jalr f001001.
  - I/J-type: ori 001101, lui 001111, lw 100011, lb 100000, sw 101011, beq 000100, j 000010, jal 000011.
- ALUOp codes: 0 ADD, 1 SUB, 2 OR, 3 LUI, 4 SLL.
  - beq uses SUB.
  - lw/lb/sw use ADD with ExtOp=1.
  - ori uses zero extend.
- retire_cnt increments by 1 on every retire pulse; it wraps from all-ones to 0.
- Without the macro, an illegal instruction flows FETCH→DECODE→EXE→FETCH as a nop: no writes, retire=1.

Optional Feature:
MC_ILLEGAL_HALT_EN
- Defined: illegal opcode/funct detected in DECODE moves to S_HALT. HALT holds all enables at 0, retire=0, and stays there until reset.
- Undefined: S_HALT does not exist; illegal instructions behave as the nop described above.

Decomposition:
- Package mc_pkg: state codes, opcode and funct constants, ALUOp codes.
- Sub-module mc_decode: combinational instruction decode (instruction class plus steering signals).
- mc_ctrl holds the state register, enable generation and retire counter.

Test Plan:
- Reset low mid-EXE of sw, released → state=0, MemWrite never pulses; next cycle FETCH with PCWrite=1, IRWrite=1.
- lw (0x8C220004) → states 0,1,2,3,4. RegWrite=1 only in WB; MemtoReg=1, ALUSrc=1, ExtOp=1, ALUOp=0; retire on cycle 5.
- beq with ComResult=1, then with ComResult=0 → EXE PCWrite=1, then PCWrite=0; both take 3 cycles, retire_cnt +1 each.
- jal (0x0C000010) → EXE PCWrite=1, RegWrite=1, RegRa=1, Jump=1; back to FETCH.
- Opcode 0x3F: with MC_ILLEGAL_HALT_EN, state=5 forever and retire_cnt frozen; without it, 3-cycle nop with no writes and retire_cnt +1.
- CNT_W=4, 16 consecutive addu → retire_cnt wraps to 0.
